// File: rtl/icache_dm.sv
// icache_dm -- direct-mapped, one-word-per-line instruction cache.
//
// It sits between the core fetch stage and the slow memory instruction port.
// A hit returns the instruction combinationally in the same cycle. A miss
// stalls fetch and fetches the word over the instrreq/abort handshake. It then
// fills the line and replays the lookup on the current pc.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   pc         fetch byte address (bits [1:0] ignored)
//   fetch_en   core requests an instruction this cycle
//   invalidate one-cycle pulse, clears every valid bit
//   instr_out  instruction at pc (meaningful when stall=0)
//   stall      fetch must hold pc and retry
//   instrreq   registered memory request
//   instradr   registered word-aligned request address
//   instr      memory read data
//   abort      memory status; low = instr valid (once armed)
//   hit_cnt    fetch hits since reset (wraps)
//   miss_cnt   misses since reset (wraps)
module icache_dm #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        invalidate,
    output logic [31:0] instr_out,
    output logic        stall,
    output logic        instrreq,
    output logic [31:0] instradr,
    input  logic [31:0] instr,
    input  logic        abort,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]       state;
    logic [31:0]      data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] fill_tag;

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             hit;
    logic             fill_fire;
    logic             unused_pc_lsb;

    // Lookup stage: the cache is purely combinational on pc.
    assign lk_idx        = pc[IDX+1:2];
    assign lk_tag        = pc[31:IDX+2];
    assign unused_pc_lsb = ^pc[1:0];
    assign hit           = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign instr_out     = data_mem[lk_idx];
    assign stall         = (state != IDLE) || (fetch_en && !hit);

    // The fill edge. A coincident invalidate wins, so the line is left invalid.
    assign fill_fire = (state == WAIT) && !abort && !invalidate;

    // Control stage: FSM, request handshake, valid bits and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            instrreq <= 1'b0;
            instradr <= 32'd0;
            valid    <= '0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        if (hit) begin
                            hit_cnt <= hit_cnt + 32'd1;
                        end else begin
                            instradr <= {pc[31:2], 2'b00};
                            instrreq <= 1'b1;
                            miss_cnt <= miss_cnt + 32'd1;
                            state    <= ARM;
                        end
                    end
                end
                // abort may still be low from the previous delivery. Only a
                // sampled high arms the wait for fresh data.
                ARM: begin
                    if (abort) state <= WAIT;
                end
                WAIT: begin
                    if (!abort) begin
                        instrreq <= 1'b0;
                        state    <= IDLE;
                        if (!invalidate) valid[fill_idx] <= 1'b1;
                    end
                end
                default: begin
                    instrreq <= 1'b0;
                    state    <= IDLE;
                end
            endcase
            if (invalidate) valid <= '0;
        end
    end

    // Data stage: latched fill target and line storage (no reset needed).
    always_ff @(posedge clk) begin
        if (state == IDLE && fetch_en && !hit) begin
            fill_idx <= lk_idx;
            fill_tag <= lk_tag;
        end
        if (!reset && fill_fire) begin
            data_mem[fill_idx] <= instr;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_en;
    logic        invalidate;
    logic [31:0] instr_out;
    logic        stall;
    logic        instrreq;
    logic [31:0] instradr;
    logic [31:0] instr;
    logic        abort;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_dm #(.LINES(16)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
        .invalidate(invalidate), .instr_out(instr_out), .stall(stall),
        .instrreq(instrreq), .instradr(instradr), .instr(instr),
        .abort(abort), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a 16-entry array indexed by (addr/4) mod 16, tag = addr/64.
    bit          m_valid [16];
    logic [31:0] m_tagv  [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          stale;
        int          lat;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h40) return 32'h2008_0005;
        if (a == 32'h44) return 32'hAC02_0000;
        return a * 32'h9E37_79B1 + 32'h55;
    endfunction

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_index(a)] && (m_tagv[m_index(a)] == a / 64);
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory side of a miss, called just after the request edge. Abort stays low
    // (stale) for `stale` cycles, goes high for lat+1 cycles, then drops with the
    // data. Returns just after the fill edge.
    task automatic serve(input int stale, input int lat, input logic [31:0] w, input bit inv);
        abort = 1'b0;
        for (int k = 0; k < stale; k++) begin
            @(negedge clk);
            check("stall_arm", stall, 1);
            check("req_arm", instrreq, 1);
            cyc();
        end
        abort = 1'b1;
        cyc();
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("req_wait", instrreq, 1);
            cyc();
        end
        abort      = 1'b0;
        instr      = w;
        invalidate = inv;
        cyc();
        invalidate = 1'b0;
        instr      = 32'hBAD0_BAD0;
        check("req_after_fill", instrreq, 0);
    endtask

    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int stale, input int lat);
        logic [31:0] wa;
        logic [31:0] w;
        int          i;
        wa = {a[31:2], 2'b00};
        w  = memword(wa);
        i  = m_index(wa);
        pc = a;
        fetch_en = 1'b1;
        @(negedge clk);
        check("lookup_stall", stall, exp_miss);
        if (!exp_miss) begin
            check("hit_data", instr_out, m_data[i]);
            cyc();
            m_hits++;
            check("hit_cnt", hit_cnt, m_hits);
        end else begin
            cyc();
            m_misses++;
            check("req_E0", instrreq, 1);
            check("instradr", instradr, wa);
            check("miss_cnt", miss_cnt, m_misses);
            // pc wanders and fetch_en drops during the miss; the fill must not care.
            pc = a ^ 32'h1234_5678;
            fetch_en = 1'b0;
            serve(stale, lat, w, 1'b0);
            m_valid[i] = 1'b1;
            m_tagv[i]  = wa / 64;
            m_data[i]  = w;
            pc = a;
            fetch_en = 1'b1;
            @(negedge clk);
            check("replay_stall", stall, 0);
            check("replay_data", instr_out, w);
            cyc();
            m_hits++;
            check("replay_hit_cnt", hit_cnt, m_hits);
        end
        fetch_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [25:0] tv;
        reset = 1'b1; pc = 32'd0; fetch_en = 1'b0; invalidate = 1'b0;
        instr = 32'd0; abort = 1'b0;
        m_clear();
        m_hits = 0; m_misses = 0;

        tbl[0] = '{32'h40, 1'b1, 1, 19};
        tbl[1] = '{32'h40, 1'b0, 0, 0};
        tbl[2] = '{32'h44, 1'b1, 2, 20};
        tbl[3] = '{32'h44, 1'b0, 0, 0};
        tbl[4] = '{32'h00, 1'b1, 0, 0};
        tbl[5] = '{32'h40, 1'b1, 1, 3};
        tbl[6] = '{32'h00, 1'b1, 3, 1};
        tbl[7] = '{32'h44, 1'b0, 0, 0};
        tbl[8] = '{32'h40, 1'b1, 0, 2};
        tbl[9] = '{32'h40, 1'b0, 0, 0};

        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall_idle", stall, 0);
        check("rst_instrreq", instrreq, 0);
        check("rst_instradr", instradr, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        pc = 32'h40; fetch_en = 1'b1;
        #1;
        check("rst_stall_fetch", stall, 1);
        fetch_en = 1'b0;
        cyc();

        // Abort toggling in IDLE must not start anything.
        abort = 1'b1; cyc(); abort = 1'b0; cyc();
        check("idle_abort_req", instrreq, 0);

        for (int k = 0; k < 10; k++)
            fetch(tbl[k].addr, tbl[k].miss, tbl[k].stale, tbl[k].lat);
        check("conflict_miss_cnt", miss_cnt, 6);

        // Invalidate while idle: the cached line must miss afterwards.
        invalidate = 1'b1; cyc(); invalidate = 1'b0;
        m_clear();
        fetch(32'h40, 1'b1, 0, 1);

        // Invalidate on the fill edge: line stays invalid and the request repeats.
        pc = 32'h48; fetch_en = 1'b1;
        cyc();
        m_misses++;
        check("col_req", instrreq, 1);
        serve(1, 2, memword(32'h48), 1'b1);
        m_clear();
        @(negedge clk);
        check("col_restall", stall, 1);
        cyc();
        m_misses++;
        check("col_rereq", instrreq, 1);
        check("col_miss_cnt", miss_cnt, m_misses);
        serve(0, 0, memword(32'h48), 1'b0);
        m_valid[m_index(32'h48)] = 1'b1;
        m_tagv[m_index(32'h48)]  = 32'h48 / 64;
        m_data[m_index(32'h48)]  = memword(32'h48);
        @(negedge clk);
        check("col_stall", stall, 0);
        check("col_data", instr_out, memword(32'h48));
        cyc();
        m_hits++;
        check("col_hit_cnt", hit_cnt, m_hits);
        fetch_en = 1'b0;

        // Randomized fetches against the model.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: tv = 26'd0;
                1: tv = 26'd1;
                default: tv = 26'h3FF_FFFF;
            endcase
            a = {tv, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) begin
                invalidate = 1'b1; cyc(); invalidate = 1'b0;
                m_clear();
            end
            if ($urandom_range(0, 3) == 0) begin
                abort = 1'($urandom_range(0, 1)); cyc(); abort = 1'b0;
            end
            fetch(a, !m_hit(a), $urandom_range(0, 3), $urandom_range(0, 5));
        end
        check("rand_hit_cnt", hit_cnt, m_hits);
        check("rand_miss_cnt", miss_cnt, m_misses);

        // Reset while waiting for data abandons the miss.
        pc = 32'h80; fetch_en = 1'b1;
        cyc();
        abort = 1'b1;
        cyc();
        reset = 1'b1; fetch_en = 1'b0;
        cyc();
        check("rstw_instrreq", instrreq, 0);
        check("rstw_hit_cnt", hit_cnt, 0);
        check("rstw_miss_cnt", miss_cnt, 0);
        reset = 1'b0;
        abort = 1'b0; instr = 32'hDEAD_BEEF;
        cyc(); cyc();
        check("rstw_late_req", instrreq, 0);
        m_clear(); m_hits = 0; m_misses = 0;
        fetch(32'h80, 1'b1, 0, 1);
        fetch(32'h44, 1'b1, 1, 1);

        // Counter wrap.
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt;
        pc = 32'h80; fetch_en = 1'b1;
        @(negedge clk);
        check("wrap_stall", stall, 0);
        cyc();
        check("wrap_hit_cnt", hit_cnt, 0);
        fetch_en = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
